// File: rtl/imm_pkg.sv
// Shared mode encodings and the immediate/target extension function for imm_ext_pipe.
package imm_pkg;

  localparam int unsigned IMM_MODE_W = 3;
  localparam int unsigned MAX_XLEN   = 64;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_ZERO   = 3'd0,
    IMM_SIGN   = 3'd1,
    IMM_LUI    = 3'd2,
    IMM_BRANCH = 3'd3,
    IMM_JUMP   = 3'd4,
    IMM_SHAMT  = 3'd5
  } imm_mode_e;

  typedef logic [MAX_XLEN-1:0] xword_t;

  // Widths arrive as elaboration constants; everything is built at MAX_XLEN, then masked to xlen.
  function automatic logic [MAX_XLEN:0] imm_extend(
    input imm_mode_e   mode,
    input xword_t      instr,
    input xword_t      pc,
    input int unsigned xlen,
    input int unsigned imm_w,
    input int unsigned jtgt_w
  );
    xword_t xmask;
    xword_t imm_z;
    xword_t imm_s;
    xword_t lui;
    xword_t jmp_lo;
    xword_t jmp_keep;
    xword_t pc4;
    xword_t val;
    logic   sgn;
    logic   err;

    sgn      = 1'b0;
    err      = 1'b0;
    xmask    = '0;
    imm_z    = '0;
    imm_s    = '0;
    jmp_lo   = '0;
    jmp_keep = '0;
    val      = '0;

    for (int unsigned i = 0; i < MAX_XLEN; i++) begin
      if (i + 1 == imm_w) sgn = instr[6'(i)];
    end

    for (int unsigned i = 0; i < MAX_XLEN; i++) begin
      xmask[6'(i)]    = (i < xlen);
      imm_z[6'(i)]    = (i < imm_w) && instr[6'(i)];
      imm_s[6'(i)]    = (i < imm_w) ? instr[6'(i)] : sgn;
      jmp_lo[6'(i)]   = (i < jtgt_w) && instr[6'(i)];
      jmp_keep[6'(i)] = (i >= jtgt_w + 2);
    end

    // LUI keeps sign of the shifted immediate above bit 2*imm_w-1
    lui = imm_z << imm_w;
    for (int unsigned i = 0; i < MAX_XLEN; i++) begin
      if (i >= 2 * imm_w) lui[6'(i)] = sgn;
    end

    pc4 = pc + MAX_XLEN'(4);

    case (mode)
      IMM_ZERO:   val = imm_z;
      IMM_SIGN:   val = imm_s;
      IMM_LUI:    val = lui;
      IMM_BRANCH: val = pc4 + (imm_s << 2);
      IMM_JUMP:   val = (pc4 & jmp_keep) | (jmp_lo << 2);
      IMM_SHAMT:  val = (imm_z >> 6) & MAX_XLEN'(31);
      default: begin
        val = '0;
        err = 1'b1;
      end
    endcase

    return {err, val & xmask};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice: output register plus one skid register, flushable.
module skid_buf #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         acc_in;
  logic         acc_out;

  // Ready comes only from skid occupancy, so out_ready never reaches in_ready
  assign in_ready  = ~skid_valid_q & ~reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    acc_in       = in_valid & ~skid_valid_q & ~flush;
    acc_out      = out_valid_q & out_ready;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || acc_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = acc_in;
        if (acc_in) out_data_d = in_data;
      end
    end else if (acc_in) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate/branch/jump target generator between decode and execute, registered behind a skid buffer.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JTGT_W = 26,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [JTGT_W-1:0]     in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_value,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  localparam int unsigned PAY_W = XLEN + TAG_W + 1;

  logic [MAX_XLEN:0] ext_c;
  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  out_pay;
  logic              unused_ext;

  assign ext_c = imm_extend(imm_mode_e'(in_mode), MAX_XLEN'(in_instr), MAX_XLEN'(in_pc),
                            XLEN, IMM_W, JTGT_W);

  // Bits above XLEN are always zero after masking
  assign unused_ext = ^ext_c;

  assign in_pay = {ext_c[MAX_XLEN], in_tag, ext_c[XLEN-1:0]};

  skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  assign {out_err, out_tag, out_value} = out_pay;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed vectors, back-pressure, flush, reset, random traffic.
module tb_imm_ext_pipe;

  typedef struct packed {
    logic        err;
    logic [4:0]  tag;
    logic [31:0] val;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [25:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [4:0]  out_tag;
  logic        out_err;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_out = 0;
  logic  last_acc;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .IMM_W(16), .JTGT_W(26), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  // Reference: MIPS rules in plain arithmetic for the 32/16/26 configuration
  function automatic beat_t ref_beat(input logic [2:0] m, input logic [25:0] ins,
                                     input logic [31:0] pc, input logic [4:0] tag);
    beat_t       b;
    logic [15:0] imm;
    logic [31:0] se;
    logic [31:0] p4;
    imm   = ins[15:0];
    se    = 32'($signed(imm));
    p4    = pc + 32'd4;
    b.tag = tag;
    b.err = 1'b0;
    case (m)
      3'd0:    b.val = 32'(imm);
      3'd1:    b.val = se;
      3'd2:    b.val = 32'(imm) * 32'd65536;
      3'd3:    b.val = p4 + se * 32'd4;
      3'd4:    b.val = (p4 & 32'hF000_0000) + 32'(ins) * 32'd4;
      3'd5:    b.val = (32'(imm) / 32'd64) % 32'd32;
      default: begin b.val = 32'd0; b.err = 1'b1; end
    endcase
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check current outputs against the model, then advance model across the edge
  task automatic cyc();
    logic  exp_rdy;
    logic  acc_in;
    logic  acc_out;
    beat_t b;
    exp_rdy = !reset && (exp_q.size() < 2);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      chk("out_value", 64'(out_value), 64'(b.val));
      chk("out_tag", 64'(out_tag), 64'(b.tag));
      chk("out_err", 64'(out_err), 64'(b.err));
    end
    acc_in  = in_valid && exp_rdy && !flush;
    acc_out = (exp_q.size() > 0) && out_ready && !reset;
    b = ref_beat(in_mode, in_instr, in_pc, in_tag);
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (acc_out) void'(exp_q.pop_front());
      if (acc_in) exp_q.push_back(b);
    end
    if (acc_out) n_out++;
    last_acc = acc_in;
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] m, input logic [25:0] ins,
                        input logic [31:0] pc, input logic [4:0] tag);
    in_valid = v;
    in_mode  = m;
    in_instr = ins;
    in_pc    = pc;
    in_tag   = tag;
  endtask

  logic [2:0]  d_mode [9];
  logic [25:0] d_ins  [9];
  logic [31:0] d_pc   [9];
  logic [31:0] d_exp  [9];
  logic        d_err  [9];

  initial begin
    int   base;
    int   idx;
    logic saw_drop;

    d_mode[0] = 3'd1; d_ins[0] = 26'h0008000; d_pc[0] = 32'h0;         d_exp[0] = 32'hFFFF8000; d_err[0] = 1'b0;
    d_mode[1] = 3'd0; d_ins[1] = 26'h0008000; d_pc[1] = 32'h0;         d_exp[1] = 32'h00008000; d_err[1] = 1'b0;
    d_mode[2] = 3'd2; d_ins[2] = 26'h0001234; d_pc[2] = 32'h0;         d_exp[2] = 32'h12340000; d_err[2] = 1'b0;
    d_mode[3] = 3'd5; d_ins[3] = 26'h00007C0; d_pc[3] = 32'h0;         d_exp[3] = 32'h0000001F; d_err[3] = 1'b0;
    d_mode[4] = 3'd3; d_ins[4] = 26'h000FFFF; d_pc[4] = 32'h00400000;  d_exp[4] = 32'h00400000; d_err[4] = 1'b0;
    d_mode[5] = 3'd4; d_ins[5] = 26'h0100000; d_pc[5] = 32'hA0000000;  d_exp[5] = 32'hA0400000; d_err[5] = 1'b0;
    d_mode[6] = 3'd3; d_ins[6] = 26'h0000001; d_pc[6] = 32'hFFFFFFF8;  d_exp[6] = 32'h00000000; d_err[6] = 1'b0;
    d_mode[7] = 3'd7; d_ins[7] = 26'h3FFFFFF; d_pc[7] = 32'h12345678;  d_exp[7] = 32'h00000000; d_err[7] = 1'b1;
    d_mode[8] = 3'd2; d_ins[8] = 26'h000ABCD; d_pc[8] = 32'h0;         d_exp[8] = 32'hABCD0000; d_err[8] = 1'b0;

    // Reset state
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_value", 64'(out_value), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one beat each, checked against fixed constants
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, d_mode[i], d_ins[i], d_pc[i], 5'(i + 3));
      cyc();
      set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
      chk("dir_valid", 64'(out_valid), 64'd1);
      chk("dir_value", 64'(out_value), 64'(d_exp[i]));
      chk("dir_tag", 64'(out_tag), 64'(i + 3));
      chk("dir_err", 64'(out_err), 64'(d_err[i]));
      cyc();
    end

    // Full throughput: 8 back-to-back beats with out_ready held high
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 3'($urandom_range(0, 5)), 26'($urandom), $urandom, 5'(i));
      cyc();
      chk("thru_acc", 64'(last_acc), 64'd1);
    end
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    cyc();
    chk("thru_count", 64'(n_out - base), 64'd8);

    // Back-pressure: consumer stalls 3 cycles from the 2nd beat
    base = n_out; idx = 0; saw_drop = 1'b0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      set_in(1'b1, 3'($urandom_range(0, 7)), 26'($urandom), $urandom, 5'(idx + 16));
      out_ready = !(c >= 1 && c <= 3);
      if (!in_ready) saw_drop = 1'b1;
      cyc();
      if (last_acc) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd8);
    chk("bp_ready_dropped", 64'(saw_drop), 64'd1);
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cyc();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_count", 64'(n_out - base), 64'd8);

    // Flush with two beats buffered and a third offered
    out_ready = 1'b0;
    set_in(1'b1, 3'd1, 26'h0001111, 32'd0, 5'd1); cyc();
    set_in(1'b1, 3'd1, 26'h0002222, 32'd0, 5'd2); cyc();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    set_in(1'b1, 3'd1, 26'h0003333, 32'd0, 5'd3); cyc();
    flush = 1'b0;
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Reset asserted mid-stream
    out_ready = 1'b0;
    set_in(1'b1, 3'd2, 26'h0004444, 32'd0, 5'd9); cyc();
    set_in(1'b1, 3'd2, 26'h0005555, 32'd0, 5'd10); cyc();
    reset = 1'b1;
    cyc();
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_value", 64'(out_value), 64'd0);
    chk("mr_out_tag", 64'(out_tag), 64'd0);
    chk("mr_out_err", 64'(out_err), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    cyc();
    reset = 1'b0;
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    #1;
    chk("mr_released", 64'(in_ready), 64'd1);

    // Random traffic with occasional flush
    for (int c = 0; c < 600; c++) begin
      set_in(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 26'($urandom),
             ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom,
             5'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      cyc();
    end
    flush = 1'b0;
    set_in(1'b0, 3'd0, 26'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cyc();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
